// File: rtl/trace_pkg.sv
// Shared definitions for the RAM write tracer USB path: packet layout,
// tag bytes and the byte serializer state encoding.
package trace_pkg;

    localparam int unsigned PKT_BITS = 24;
    localparam logic [7:0]  TAG_DATA = 8'hAA;
    localparam logic [7:0]  TAG_OVF  = 8'hFF;

    // State names the byte of the current packet presented on the bus.
    typedef enum logic [1:0] {
        SER_IDLE,
        SER_B2,
        SER_B1,
        SER_B0
    } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: register array, read/write pointers and an occupancy count.
// Head entry is visible combinationally on rd_data; writes into a full FIFO are refused.
module sync_fifo #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  wr_fire;
    logic                  rd_fire;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_fire  = wr_en && !full;
        rd_fire  = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_fire && !rd_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_fire && !wr_fire) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/usb_trace_streamer.sv
// Buffers 3-byte trace packets and serializes them MSB-first onto the FX2 slave FIFO bus,
// generating IFCLK = mclk/2 and reporting FIFO overflow drops with an in-band marker packet.
module usb_trace_streamer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic [PKT_BITS-1:0]   pkt_data,
    input  logic                  pkt_strobe,
    input  logic                  usb_full,
    output logic [7:0]            usb_d,
    output logic                  usb_wr_strobe,
    output logic                  usb_ifclk,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    ser_state_t    state_q, state_d;
    logic          ifclk_q, ifclk_d;
    logic [7:0]    usb_d_q, usb_d_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [15:0]   pkt_lo_q, pkt_lo_d;
    logic          ovf_pending_q, ovf_pending_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_count_q, drop_count_d;

    logic                fifo_wr_en;
    logic [PKT_BITS-1:0] fifo_wr_data;
    logic                fifo_rd_en;
    logic [PKT_BITS-1:0] fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;

    logic marker_wr;
    logic pkt_wr;
    logic pkt_drop;

    sync_fifo #(
        .WIDTH      (PKT_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (mclk),
        .reset   (reset),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level)
    );

    // A pending marker claims the first free slot, so a same-cycle packet is lost.
    always_comb begin
        marker_wr     = ovf_pending_q && !fifo_full;
        pkt_wr        = pkt_strobe && !fifo_full && !ovf_pending_q;
        pkt_drop      = pkt_strobe && (fifo_full || ovf_pending_q);
        fifo_wr_en    = marker_wr || pkt_wr;
        fifo_wr_data  = marker_wr ? {TAG_OVF, drop_count_q} : pkt_data;
        ovf_pending_d = ovf_pending_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q || pkt_drop;
        if (marker_wr) begin
            ovf_pending_d = pkt_drop;
            drop_count_d  = pkt_drop ? 16'd1 : 16'd0;
        end else if (pkt_drop) begin
            ovf_pending_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ifclk_d     = 1'b1;
        usb_d_d     = usb_d_q;
        wr_strobe_d = wr_strobe_q;
        pkt_lo_d    = pkt_lo_q;
        fifo_rd_en  = 1'b0;
        if (ifclk_q) begin
            ifclk_d = 1'b0;
            case (state_q)
                SER_IDLE, SER_B0: begin
                    if (!fifo_empty && !usb_full) begin
                        fifo_rd_en  = 1'b1;
                        usb_d_d     = fifo_rd_data[23:16];
                        pkt_lo_d    = fifo_rd_data[15:0];
                        wr_strobe_d = 1'b1;
                        state_d     = SER_B2;
                    end else begin
                        wr_strobe_d = 1'b0;
                        state_d     = (state_q == SER_B0 && usb_full) ? SER_B0 : SER_IDLE;
                    end
                end
                SER_B2: begin
                    wr_strobe_d = !usb_full;
                    if (!usb_full) begin
                        usb_d_d = pkt_lo_q[15:8];
                        state_d = SER_B1;
                    end
                end
                SER_B1: begin
                    wr_strobe_d = !usb_full;
                    if (!usb_full) begin
                        usb_d_d = pkt_lo_q[7:0];
                        state_d = SER_B0;
                    end
                end
                default: begin
                    wr_strobe_d = 1'b0;
                    state_d     = SER_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q       <= SER_IDLE;
            ifclk_q       <= 1'b0;
            usb_d_q       <= '0;
            wr_strobe_q   <= 1'b0;
            pkt_lo_q      <= '0;
            ovf_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            ifclk_q       <= ifclk_d;
            usb_d_q       <= usb_d_d;
            wr_strobe_q   <= wr_strobe_d;
            pkt_lo_q      <= pkt_lo_d;
            ovf_pending_q <= ovf_pending_d;
            overflow_q    <= overflow_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign usb_d         = usb_d_q;
    assign usb_wr_strobe = wr_strobe_q;
    assign usb_ifclk     = ifclk_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_usb_trace_streamer.sv
// Directed bench for usb_trace_streamer: bytes are taken where the FX2 would latch them
// (usb_ifclk high with usb_wr_strobe high) and compared to hand-computed packet bytes.
module tb_usb_trace_streamer;

    logic        mclk = 1'b0;
    logic        reset;
    logic [23:0] pkt_data;
    logic        pkt_strobe;
    logic        usb_full;
    logic [7:0]  usb_d;
    logic        usb_wr_strobe;
    logic        usb_ifclk;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #10 mclk = ~mclk;

    usb_trace_streamer #(
        .DEPTH_LOG2 (4)
    ) dut (
        .mclk          (mclk),
        .reset         (reset),
        .pkt_data      (pkt_data),
        .pkt_strobe    (pkt_strobe),
        .usb_full      (usb_full),
        .usb_d         (usb_d),
        .usb_wr_strobe (usb_wr_strobe),
        .usb_ifclk     (usb_ifclk),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_byte(input string tag, input logic [7:0] exp, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (usb_ifclk === 1'b1 && usb_wr_strobe === 1'b1) got = 1'b1;
        end
        chk({tag, "_seen"}, {31'd0, got}, 32'd1);
        if (got) chk(tag, {24'd0, usb_d}, {24'd0, exp});
    endtask

    task automatic drain_pkt(input string tag, input logic [23:0] pkt, input int first_budget);
        wait_byte({tag, "_b2"}, pkt[23:16], first_budget);
        wait_byte({tag, "_b1"}, pkt[15:8], 2);
        wait_byte({tag, "_b0"}, pkt[7:0], 2);
    endtask

    task automatic quiet(input string tag, input int n);
        int c;
        c = 0;
        repeat (n) begin
            step();
            if (usb_ifclk === 1'b1 && usb_wr_strobe === 1'b1) c++;
        end
        chk(tag, c, 0);
    endtask

    task automatic send_pkt(input logic [23:0] d);
        pkt_data   = d;
        pkt_strobe = 1'b1;
        step();
        pkt_strobe = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_usb_d"}, {24'd0, usb_d}, 32'd0);
        chk({tag, "_wr_strobe"}, {31'd0, usb_wr_strobe}, 32'd0);
        chk({tag, "_ifclk"}, {31'd0, usb_ifclk}, 32'd0);
        chk({tag, "_level"}, {27'd0, fifo_level}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_drop_count"}, {16'd0, drop_count}, 32'd0);
    endtask

    initial begin
        logic got;
        reset      = 1'b1;
        pkt_data   = '0;
        pkt_strobe = 1'b0;
        usb_full   = 1'b0;

        // Reset values
        repeat (3) step();
        chk_reset_state("rst");
        reset = 1'b0;
        step();

        // Single packet, unstalled
        send_pkt(24'h012345);
        chk("t2_level_up", {27'd0, fifo_level}, 32'd1);
        wait_byte("t2_b2", 8'h01, 5);
        chk("t2_level_down", {27'd0, fifo_level}, 32'd0);
        wait_byte("t2_b1", 8'h23, 2);
        wait_byte("t2_b0", 8'h45, 2);
        quiet("t2_no_extra", 6);
        chk("t2_strobe_low", {31'd0, usb_wr_strobe}, 32'd0);

        // Fill with usb_full held, one overflow drop, then drain with marker
        usb_full = 1'b1;
        for (int i = 0; i < 16; i++) send_pkt(24'h120000 + 24'(i));
        chk("t3_level_full", {27'd0, fifo_level}, 32'd16);
        chk("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        send_pkt(24'h777777);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_drop1", {16'd0, drop_count}, 32'd1);
        chk("t3_level_still", {27'd0, fifo_level}, 32'd16);
        usb_full = 1'b0;
        for (int i = 0; i < 16; i++)
            drain_pkt($sformatf("t3_p%0d", i), 24'h120000 + 24'(i), (i == 0) ? 5 : 2);
        drain_pkt("t3_marker", 24'hFF0001, 2);
        chk("t3_drop_cleared", {16'd0, drop_count}, 32'd0);
        chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
        quiet("t3_no_extra", 6);

        // Stall of three update cycles between byte 2 and byte 3
        send_pkt(24'hAABEEF);
        wait_byte("t4_b2", 8'hAA, 5);
        wait_byte("t4_b1", 8'hBE, 2);
        usb_full = 1'b1;
        quiet("t4_stalled", 5);
        chk("t4_hold_d", {24'd0, usb_d}, 32'h0000_00BE);
        usb_full = 1'b0;
        wait_byte("t4_b0", 8'hEF, 4);
        quiet("t4_no_extra", 6);

        // Marker and packet strobe in the cycle a slot frees
        usb_full = 1'b1;
        for (int i = 0; i < 16; i++) send_pkt(24'h340000 + 24'(i));
        for (int i = 0; i < 5; i++) send_pkt(24'h888888);
        chk("t5_drop5", {16'd0, drop_count}, 32'd5);
        usb_full = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (fifo_level == 5'd15) got = 1'b1;
        end
        chk("t5_slot_free", {31'd0, got}, 32'd1);
        pkt_data   = 24'h999999;
        pkt_strobe = 1'b1;
        step();
        pkt_strobe = 1'b0;
        chk("t5_drop_restart", {16'd0, drop_count}, 32'd1);
        chk("t5_level_refill", {27'd0, fifo_level}, 32'd16);
        chk("t5_p0_b2_strobe", {31'd0, usb_wr_strobe & usb_ifclk}, 32'd1);
        chk("t5_p0_b2", {24'd0, usb_d}, 32'h0000_0034);
        wait_byte("t5_p0_b1", 8'h00, 2);
        wait_byte("t5_p0_b0", 8'h00, 2);
        for (int i = 1; i < 16; i++)
            drain_pkt($sformatf("t5_p%0d", i), 24'h340000 + 24'(i), 2);
        drain_pkt("t5_marker5", 24'hFF0005, 2);
        drain_pkt("t5_marker1", 24'hFF0001, 2);
        chk("t5_drop_cleared", {16'd0, drop_count}, 32'd0);
        quiet("t5_no_extra", 6);

        // Drop counter saturation
        usb_full = 1'b1;
        for (int i = 0; i < 16; i++) send_pkt(24'h5A0000 + 24'(i));
        pkt_data   = 24'h424242;
        pkt_strobe = 1'b1;
        repeat (70000) step();
        pkt_strobe = 1'b0;
        chk("t6_saturated", {16'd0, drop_count}, 32'h0000_FFFF);
        chk("t6_level_full", {27'd0, fifo_level}, 32'd16);
        usb_full = 1'b0;
        for (int i = 0; i < 16; i++)
            drain_pkt($sformatf("t6_p%0d", i), 24'h5A0000 + 24'(i), (i == 0) ? 5 : 2);
        drain_pkt("t6_marker", 24'hFFFFFF, 2);
        chk("t6_drop_cleared", {16'd0, drop_count}, 32'd0);
        quiet("t6_no_extra", 6);

        // Reset while byte 1 is on the bus, with a second packet queued
        send_pkt(24'h56789A);
        send_pkt(24'h111111);
        wait_byte("t7_b2", 8'h56, 5);
        wait_byte("t7_b1", 8'h78, 2);
        chk("t7_queued", {27'd0, fifo_level}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("t7_rst");
        quiet("t7_abandoned", 8);
        send_pkt(24'h0ABCDE);
        drain_pkt("t7_after", 24'h0ABCDE, 5);
        quiet("t7_no_extra", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
